dec_result_collector: RTL
=========================

Name: dec_result_collector

Overview:
- Downstream stage of the SECDED decoder. Captures each enabled decode result (data_out, num_of_errors, codeword_width) into a small synchronous FIFO.
- Presents results to the consumer over a valid/ready interface.
- Keeps saturating statistics of corrected and uncorrectable events, plus a sticky overflow flag for results lost when the FIFO is full.

Parameters:
- DATA_WIDTH, 32, width of decoded data word; must match decoder DATA_WIDTH.
- FIFO_DEPTH, 4, number of result entries; power of two, ≥2.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode result present this cycle (driven by the decoder's enable).
- in_data  in  DATA_WIDTH  decoder data_out, zero-extended data field.
- in_num_of_errors  in  2  decoder num_of_errors: 00 clean, 01 single corrected, 10/11 uncorrectable.
- in_codeword_width  in  2  codeword_width that accompanied the decode.
- in_ready  out  1  FIFO can accept; = not full.
- out_valid  out  1  head entry available; = not empty.
- out_ready  in  1  consumer takes head this cycle.
- out_data  out  DATA_WIDTH  head data; all-zero when empty.
- out_num_of_errors  out  2  head error code; 00 when empty.
- out_codeword_width  out  2  head width code; 00 when empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- corrected_cnt  out  CNT_WIDTH  accepted entries with code 01.
- uncorrectable_cnt  out  CNT_WIDTH  accepted entries with code 10 or 11.
- overflow  out  1  sticky: a result was offered while full.
- clear_stats  in  1  clears both counters and overflow.

Behaviour:
- Reset (rst=1 at edge): wr_ptr=rd_ptr=0, fifo_count=0, both counters=0, overflow=0. Resulting outputs: out_valid=0, out_* all zero, in_ready=1. Reset wins over every other input. Reset mid-transfer discards all stored entries. Entry storage need not be cleared, because outputs are masked while empty.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Push writes {in_data, in_num_of_errors, in_codeword_width} at wr_ptr; wr_ptr increments modulo FIFO_DEPTH (natural wrap).
- Pop advances rd_ptr modulo FIFO_DEPTH.
- Occupancy: push&pop → unchanged; push only → +1; pop only → −1.
- Full (count=FIFO_DEPTH): in_ready=0 combinationally. There is no same-cycle pass-through when full: a push is refused even if pop=1 in that cycle.
- Empty: a pop is impossible (out_valid=0); out_ready is ignored.
- Latency: an entry pushed at edge N is visible on out_* after edge N (first cycle with out_valid=1 is N+1).
- Order is strictly FIFO.
- out_* are combinational reads of the head entry gated by out_valid. They are stable while out_valid=1 and out_ready=0.
- Dropped result: in_valid=1 & in_ready=0 → the result is discarded, overflow←1 (sticky), and the counters are not updated.
- Statistics update only on push:
  - code 01 → corrected_cnt+1.
  - code 10/11 → uncorrectable_cnt+1.
  - code 00 → no change.
- Counters saturate at 2^CNT_WIDTH−1 and do not wrap.
- clear_stats=1: both counters←0 and overflow←0. If a push occurs in the same cycle, its event is counted after the clear, so the affected counter becomes 1. If a drop occurs in the same cycle, overflow ends at 1.
- in_codeword_width is stored and returned unchanged; it is not interpreted by this block.

Test Plan:
- Reset: hold rst=1 two cycles with in_valid=1 → fifo_count=0, out_valid=0, out_data=0, counters=0, overflow=0, in_ready=1.
- Order/latency: push data 0x5, 0x7FF, 0x3FFFFFF (codes 00, 01, 10) with out_ready=0 → fifo_count=3, corrected_cnt=1, uncorrectable_cnt=1. Then out_ready=1 → outputs appear in that order, one per cycle, and out_valid drops after the third pop.
- Full/overflow: 4 pushes with out_ready=0, then a 5th push of 0xAA → in_ready=0, overflow=1, fifo_count=4, counters unchanged by the 5th push. Drain → 0xAA never appears.
- Simultaneous push and pop: at count 2, in_valid=out_ready=1 for 5 cycles → fifo_count stays 2 throughout, pointers wrap past depth, and data order is preserved.
- Saturation and clear (CNT_WIDTH=4): 17 code-01 pushes → corrected_cnt=15. Then clear_stats=1 with a simultaneous code-01 push → corrected_cnt=1, overflow=0.
- Reset mid-operation: 3 entries stored, then rst=1 for one cycle while out_ready=1 → next cycle fifo_count=0, out_valid=0, and no stored entry is returned afterwards.

Source files
------------

// File: rtl/dec_result_collector.sv
// Result collector behind the SECDED decoder: buffers decode results in a small
// FIFO, hands them out over valid/ready and keeps saturating error statistics.
module dec_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [1:0]                    in_num_of_errors,
  input  logic [1:0]                    in_codeword_width,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [1:0]                    out_num_of_errors,
  output logic [1:0]                    out_codeword_width,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          corrected_cnt,
  output logic [CNT_WIDTH-1:0]          uncorrectable_cnt,
  output logic                          overflow,
  input  logic                          clear_stats
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0]        PTR_ONE = PW'(1);
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] STAT_MAX = {CNT_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] data_mem_q  [FIFO_DEPTH];
  logic [1:0]            code_mem_q  [FIFO_DEPTH];
  logic [1:0]            width_mem_q [FIFO_DEPTH];

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CNT_WIDTH-1:0] corr_q, corr_d, unc_q, unc_d;
  logic                 ovf_q, ovf_d;
  logic                 push_s, pop_s;

  assign in_ready          = (count_q != DEPTH_C);
  assign out_valid         = (count_q != '0);
  assign fifo_count        = count_q;
  assign corrected_cnt     = corr_q;
  assign uncorrectable_cnt = unc_q;
  assign overflow          = ovf_q;

  // Head entry, forced to zero whenever nothing is stored
  always_comb begin
    if (out_valid) begin
      out_data           = data_mem_q[rd_ptr_q];
      out_num_of_errors  = code_mem_q[rd_ptr_q];
      out_codeword_width = width_mem_q[rd_ptr_q];
    end else begin
      out_data           = '0;
      out_num_of_errors  = 2'b00;
      out_codeword_width = 2'b00;
    end
  end

  // Next-state for pointers, occupancy and statistics
  always_comb begin
    push_s   = in_valid & in_ready;
    pop_s    = out_valid & out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Clear first so a same-cycle event lands on top of the cleared value
    if (clear_stats) begin
      corr_d = '0;
      unc_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      corr_d = corr_q;
      unc_d  = unc_q;
      ovf_d  = ovf_q;
    end
    if (in_valid & ~in_ready) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    if (push_s) begin
      case (in_num_of_errors)
        2'b01:        if (corr_d != STAT_MAX) corr_d = corr_d + STAT_ONE; else corr_d = corr_d;
        2'b10, 2'b11: if (unc_d != STAT_MAX) unc_d = unc_d + STAT_ONE; else unc_d = unc_d;
        default:      corr_d = corr_d;
      endcase
    end else begin
      corr_d = corr_d;
    end
  end

  // Control and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      corr_q   <= '0;
      unc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      corr_q   <= corr_d;
      unc_q    <= unc_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; never read while empty, so it carries no reset
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      data_mem_q[wr_ptr_q]  <= in_data;
      code_mem_q[wr_ptr_q]  <= in_num_of_errors;
      width_mem_q[wr_ptr_q] <= in_codeword_width;
    end
  end

endmodule
